divider_ctrl: RTL and testbench
===============================

DIVIDER_CTRL -- requirements
Module: divider_ctrl

Interface
REQ-001 Parameter WIDTH, default 17: width of the divide-ratio register and period counter.
REQ-002 Parameter CNT_W, default 8: width of the tick counter.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserting low clears all state immediately, independent of clock.
REQ-005 cfg_valid  input  1  new divide ratio offered on cfg_div.
REQ-006 cfg_div  input  WIDTH  terminal count N; tick period is N+1 clock cycles.
REQ-007 cfg_ready  output  1  block accepts cfg_div this cycle; transfer occurs when cfg_valid and cfg_ready are both high.
REQ-008 start  input  1  one-cycle request to begin ticking.
REQ-009 stop  input  1  one-cycle request to stop after the current period.
REQ-010 tick  output  1  one-cycle pulse at each period end.
REQ-011 div_clock  output  1  toggles on each tick, giving a square wave of period 2(N+1).
REQ-012 busy  output  1  high in RUN and STOP_PEND.
REQ-013 tick_count  output  CNT_W  number of ticks since the last start.

Function
REQ-014 States: IDLE, RUN and STOP_PEND. Encoding is free. All outputs are registered except cfg_ready.
REQ-015 Registers: div_reg (WIDTH bits), shadow (WIDTH bits), pend (1 bit), cnt (WIDTH bits).
REQ-016 IDLE:
- cnt is held at 0 and tick stays 0.
- cfg_ready=1.
- An accepted cfg loads div_reg directly on that edge.
REQ-017 IDLE with start=1 and stop=0: go to RUN, clear cnt and tick_count, and leave div_clock unchanged.
REQ-018 IDLE with start=1 and stop=1 in the same cycle: stop wins and the block stays in IDLE.
REQ-019 IDLE with cfg accepted and start in the same cycle: the first period uses the newly accepted cfg_div.
REQ-020 RUN or STOP_PEND with cnt!=div_reg: cnt increments by 1.
REQ-021 RUN or STOP_PEND with cnt==div_reg (period end), on the same edge:
- tick=1 for exactly one cycle.
- cnt returns to 0.
- div_clock inverts.
- tick_count increments, wrapping from 2^CNT_W-1 to 0.
REQ-022 div_reg=0 gives tick=1 every cycle and div_clock toggling every cycle.
REQ-023 In RUN or STOP_PEND, cfg_ready = !pend.
REQ-024 An accepted cfg in RUN or STOP_PEND writes shadow and sets pend; div_reg is not changed mid-period.
REQ-025 At period end with pend=1, div_reg is loaded from shadow and pend is cleared; the next period uses the new value.
REQ-026 When a cfg is accepted on the same edge as a period end with pend=0, it is applied at the following period end.
REQ-027 RUN with stop=1: go to STOP_PEND; the current period completes.
REQ-028 STOP_PEND at period end: emit the final tick, then go to IDLE; cnt becomes 0 and div_clock holds its value.
REQ-029 STOP_PEND with start=1 (and no period end): cancel the stop and return to RUN without disturbing cnt.
REQ-030 STOP_PEND with start=1 on the same edge as period end: the block remains in RUN.
REQ-031 RUN with start=1: ignored.
REQ-032 STOP_PEND with stop=1: ignored.
REQ-033 Entering IDLE with pend=1: shadow is moved into div_reg and pend is cleared.

Reset
REQ-034 reset low forces, asynchronously:
- state=IDLE.
- cnt, div_reg, shadow, pend, tick_count all 0.
- tick=0, div_clock=0, busy=0.
- cfg_ready=1.
REQ-035 Reset asserted mid-period aborts the period with no tick; operation after release starts from IDLE.
REQ-036 No input is sampled while reset is low.

Verification
REQ-037 Basic ratio: cfg_div=3 in IDLE, start -> tick on cycles 4, 8, 12 after start; div_clock period 8 cycles; tick_count=3 after the third tick.
REQ-038 Divide-by-one: cfg_div=0, start -> tick high every cycle; div_clock toggles every cycle; after 255 ticks tick_count=255, and the next tick wraps it to 0.
REQ-039 Reconfigure in flight: run with N=4, send cfg_div=1 at cnt=2 -> cfg_ready drops to 0, the current period still ends at cnt=4, the following periods are 2 cycles, and cfg_ready returns to 1.
REQ-040 Stop and cancel:
- N=5, stop at cnt=1 -> busy holds until cnt=5, one final tick, then IDLE.
- Repeat, with start at cnt=3 -> remains RUN and ticking continues.
- start+stop together in IDLE -> stays IDLE.
REQ-041 Asynchronous reset: pull reset low mid-period between clock edges -> outputs clear before the next edge, no tick is emitted, cfg_ready=1, div_reg=0.

Source files
------------

// File: rtl/divider_ctrl.sv
// Programmable clock divider: emits a one-cycle tick every N+1 cycles plus a 50%-duty div_clock.
// Ratio changes made while running are staged in a shadow register and applied at the next period end.
module divider_ctrl #(
  parameter int WIDTH = 17,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,      // active low, asynchronous
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  input  logic             start,
  input  logic             stop,
  output logic             tick,
  output logic             div_clock,
  output logic             busy,
  output logic [CNT_W-1:0] tick_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STOP_PEND = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] div_reg, div_next;
  logic [WIDTH-1:0] shadow_reg, shadow_next;
  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic             pend_reg, pend_next;
  logic             tick_reg, tick_next;
  logic             div_clock_reg, div_clock_next;
  logic             busy_reg, busy_next;
  logic [CNT_W-1:0] tick_count_reg, tick_count_next;

  logic active;
  logic period_end;
  logic cfg_fire;

  assign active     = (state_reg != IDLE);
  assign period_end = active && (cnt_reg == div_reg);
  assign cfg_ready  = active ? !pend_reg : 1'b1;
  assign cfg_fire   = cfg_valid && cfg_ready;

  assign tick       = tick_reg;
  assign div_clock  = div_clock_reg;
  assign busy       = busy_reg;
  assign tick_count = tick_count_reg;

  always_comb begin
    state_next      = state_reg;
    div_next        = div_reg;
    shadow_next     = shadow_reg;
    pend_next       = pend_reg;
    cnt_next        = cnt_reg;
    tick_next       = 1'b0;
    div_clock_next  = div_clock_reg;
    tick_count_next = tick_count_reg;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (cfg_fire) begin
          div_next = cfg_div;
        end
        if (start && !stop) begin
          state_next      = RUN;
          tick_count_next = '0;
        end
      end

      RUN, STOP_PEND: begin
        if (period_end) begin
          tick_next       = 1'b1;
          cnt_next        = '0;
          div_clock_next  = !div_clock_reg;
          tick_count_next = tick_count_reg + CNT_W'(1);
          if (pend_reg) begin
            div_next  = shadow_reg;
            pend_next = 1'b0;
          end
        end else begin
          cnt_next = cnt_reg + WIDTH'(1);
        end

        // cfg_fire implies pend_reg is clear, so this never races the shadow load above
        if (cfg_fire) begin
          shadow_next = cfg_div;
          pend_next   = 1'b1;
        end

        if (state_reg == RUN) begin
          if (stop) begin
            state_next = STOP_PEND;
          end
        end else if (start) begin
          state_next = RUN;
        end else if (period_end) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    // A ratio staged on the final edge of a stop must not be stranded in the shadow
    if ((state_next == IDLE) && pend_next) begin
      div_next  = shadow_next;
      pend_next = 1'b0;
    end

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      div_reg        <= '0;
      shadow_reg     <= '0;
      cnt_reg        <= '0;
      pend_reg       <= 1'b0;
      tick_reg       <= 1'b0;
      div_clock_reg  <= 1'b0;
      busy_reg       <= 1'b0;
      tick_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      div_reg        <= div_next;
      shadow_reg     <= shadow_next;
      cnt_reg        <= cnt_next;
      pend_reg       <= pend_next;
      tick_reg       <= tick_next;
      div_clock_reg  <= div_clock_next;
      busy_reg       <= busy_next;
      tick_count_reg <= tick_count_next;
    end
  end

endmodule

// File: tb/tb_divider_ctrl.sv
// Bench for divider_ctrl: directed scenarios plus random traffic, all checked against a
// period-length/phase reference model with a queue holding the staged ratio.
module tb_divider_ctrl;
  localparam int WIDTH = 17;
  localparam int CNT_W = 8;
  localparam int TMOD  = 1 << CNT_W;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [WIDTH-1:0] cfg_div = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             cfg_ready;
  logic             tick;
  logic             div_clock;
  logic             busy;
  logic [CNT_W-1:0] tick_count;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: mode 0=idle 1=running 2=stopping; period length = ratio+1
  int m_mode, m_len, m_phase, m_ticks;
  bit m_dclk, m_tick;
  int m_pend[$];

  always #5 clock = ~clock;

  divider_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .start(start), .stop(stop), .tick(tick),
    .div_clock(div_clock), .busy(busy), .tick_count(tick_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_len = 1; m_phase = 0; m_ticks = 0;
    m_dclk = 1'b0; m_tick = 1'b0;
    m_pend.delete();
  endtask

  function automatic bit model_ready();
    return (m_mode == 0) || (m_pend.size() == 0);
  endfunction

  task automatic model_edge(input bit cv, input int cd, input bit st, input bit sp);
    bit take;
    bit ends;
    take   = cv && model_ready();
    m_tick = 1'b0;
    if (m_mode == 0) begin
      m_phase = 0;
      if (take) m_len = cd + 1;
      if (st && !sp) begin
        m_mode  = 1;
        m_ticks = 0;
      end
    end else begin
      ends = (m_phase + 1 == m_len);
      if (ends) begin
        m_tick  = 1'b1;
        m_phase = 0;
        m_dclk  = !m_dclk;
        m_ticks = (m_ticks + 1) % TMOD;
        if (m_pend.size() > 0) m_len = m_pend.pop_front() + 1;
      end else begin
        m_phase++;
      end
      if (take) m_pend.push_back(cd);
      if (m_mode == 1) begin
        if (sp) m_mode = 2;
      end else if (st) begin
        m_mode = 1;
      end else if (ends) begin
        m_mode = 0;
      end
    end
    if (m_mode == 0 && m_pend.size() > 0) m_len = m_pend.pop_front() + 1;
  endtask

  task automatic step(input bit cv, input int cd, input bit st, input bit sp);
    @(negedge clock);
    check("cfg_ready", cfg_ready, model_ready());
    cfg_valid = cv;
    cfg_div   = cd[WIDTH-1:0];
    start     = st;
    stop      = sp;
    if (cv || st || sp)
      $display("[%0t] txn cfg_valid=%0b cfg_div=%0d start=%0b stop=%0b", $time, cv, cd, st, sp);
    @(posedge clock);
    model_edge(cv, cd, st, sp);
    #1;
    check("tick", tick, m_tick);
    check("div_clock", div_clock, m_dclk);
    check("busy", busy, m_mode != 0);
    check("tick_count", tick_count, m_ticks);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("rst_tick", tick, 0);
    check("rst_div_clock", div_clock, 0);
    check("rst_busy", busy, 0);
    check("rst_tick_count", tick_count, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    @(negedge clock);
    reset = 1'b1;

    // Basic ratio N=3: ticks exactly 4, 8, 12 cycles after start
    step(1, 3, 0, 0);
    step(0, 0, 1, 0);
    for (int k = 1; k <= 12; k++) begin
      step(0, 0, 0, 0);
      check($sformatf("basic_tick_c%0d", k), tick, (k % 4) == 0);
    end
    check("basic_tick_count", tick_count, 3);
    step(0, 0, 0, 1);
    idle(5);

    // Divide-by-one with tick_count wrap
    step(1, 0, 1, 0);
    for (int k = 1; k <= 255; k++) step(0, 0, 0, 0);
    check("div1_count_255", tick_count, 255);
    step(0, 0, 0, 0);
    check("div1_count_wrap", tick_count, 0);
    step(0, 0, 0, 1);
    idle(2);

    // Reconfigure in flight: N=4, new ratio 1 offered at cnt=2
    step(1, 4, 1, 0);
    idle(2);
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    check("reconf_ready_low", cfg_ready, 0);
    idle(8);
    check("reconf_ready_back", cfg_ready, 1);
    step(0, 0, 0, 1);
    idle(3);

    // Stop at cnt=1 with N=5, then stop followed by cancel at cnt=3
    step(1, 5, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    idle(6);
    check("stop_back_idle", busy, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    idle(1);
    step(0, 0, 1, 0);
    idle(12);
    check("cancel_still_busy", busy, 1);
    step(0, 0, 0, 1);
    idle(7);
    step(0, 0, 1, 1);
    idle(2);
    check("start_stop_idle", busy, 0);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 9) == 0, $urandom_range(0, 6),
           $urandom_range(0, 19) == 0, $urandom_range(0, 24) == 0);
    end
    step(0, 0, 0, 1);
    idle(10);

    // Asynchronous reset mid-period, inputs ignored while low
    step(1, 5, 1, 0);
    idle(2);
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("arst_tick", tick, 0);
    check("arst_div_clock", div_clock, 0);
    check("arst_busy", busy, 0);
    check("arst_tick_count", tick_count, 0);
    check("arst_cfg_ready", cfg_ready, 1);
    cfg_valid = 1'b1; cfg_div = 7; start = 1'b1;
    @(posedge clock);
    #1;
    check("arst_no_tick", tick, 0);
    check("arst_held_idle", busy, 0);
    @(negedge clock);
    cfg_valid = 1'b0; start = 1'b0;
    reset = 1'b1;
    // div_reg must be 0 after reset: start alone gives a tick every cycle
    step(0, 0, 1, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0);
      check("arst_div0_tick", tick, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
